receive: RTL
============

# receive

Instruction-fetch receiver; the requesting end of the syn/ack instruction channel. It issues `r_o_syn` requests to the instruction transmitter and captures every acknowledged word into a small FIFO. Each word is tagged with its sequence index, and words are presented to the CPU front end through a valid/ready interface. It sits between the instruction source and the decode stage, sharing their clock and reset.

## Interface
- `IWIDTH`, 32, instruction width in bits.
- `DEPTH`, 36, number of words in the transmitter's program; the index wraps at `DEPTH-1`.
- `FDEPTH`, 4, FIFO entries; a power of two, ≥ 2.
- `IDXW`, `$clog2(DEPTH)`, width of the index output.
- `r_clk` input 1: the single clock; all state changes on the rising edge.
- `r_rst` input 1: reset; **asynchronous, active-low**.
- `r_i_en` input 1: fetch enable; while 0, no new requests are issued.
- `r_o_syn` output 1: request to the transmitter; one word is requested per cycle high.
- `r_i_instr` input IWIDTH: word from the transmitter; valid when `r_i_ack` is 1.
- `r_i_ack` input 1: transmitter response; one word per cycle high.
- `r_o_instr` output IWIDTH: head-of-FIFO instruction.
- `r_o_idx` output IDXW: sequence index of the head word.
- `r_o_last` output 1: 1 when the head index equals `DEPTH-1`.
- `r_o_valid` output 1: FIFO not empty.
- `r_i_ready` input 1: downstream accepts the head word on a cycle where valid and ready are both 1 (pop).
- `r_o_err` output 1: sticky overflow flag.

## Operation
- **Channel protocol.** The transmitter registers its response. A request with `r_o_syn`=1 sampled at edge k produces `r_i_ack`=1 with data during the cycle after edge k.
  - Back-to-back requests yield back-to-back acks, each carrying a new word.
  - Every cycle with `r_i_ack`=1 is exactly one word.
- **Inflight tracking.** `inflight` is a register holding the `r_o_syn` value of the previous cycle.
- **Request rule (credit scheme).** `r_o_syn = r_i_en && (count + inflight < FDEPTH)`.
  - This is combinational from `r_i_en` and internal registers only; it has no path from `r_i_ack` or `r_i_ready`.
  - A pop in the same cycle is not credited.
  - `r_o_syn` is forced to 0 while `r_rst` is low.
- **Push.** A push occurs when `r_i_ack`=1. The entry stores `{r_i_instr, seq}`; then `seq <= (seq == DEPTH-1) ? 0 : seq+1`.
- **Pop.** A pop occurs when `r_o_valid && r_i_ready`.
- **Simultaneous push and pop.** Both are allowed in the same cycle, including when the FIFO is full; `count` is then unchanged.
- **Overflow.** `r_i_ack`=1 while `count == FDEPTH` and no pop:
  - the word is dropped and `seq` still advances, keeping it aligned with the transmitter counter;
  - `r_o_err` is set to 1 and holds until reset.
- **Enable deasserted.** When `r_i_en` falls, requests stop immediately. One ack may still arrive and is accepted, because the credit rule guarantees space for it.
- **Head outputs.** `r_o_instr`, `r_o_idx` and `r_o_last` always reflect the entry at the read pointer. When the FIFO is empty they hold the last entry's values.
- **Reset, including mid-operation.** Reset is assumed shared with the transmitter, so any in-flight word is discarded on both sides. Reset clears:
  - FIFO storage, pointers and `count`;
  - `seq`, `inflight` and `r_o_err`.
- **Reset values.** `r_o_syn` 0, `r_o_valid` 0, `r_o_instr` 0, `r_o_idx` 0, `r_o_last` 0, `r_o_err` 0.

## Timing
- **Latency.** `r_i_en` rises in cycle 0 with the FIFO empty:
  - `r_o_syn`=1 in cycle 0;
  - ack in cycle 1;
  - `r_o_valid`=1 in cycle 2 with index 0.
- **Throughput.** One word per cycle sustained when `r_i_ready` is held at 1.
- **Pointers and count.** Pointers are `$clog2(FDEPTH)` bits, wrapping naturally. `count` is `$clog2(FDEPTH+1)` bits.
- **Backpressure.** With `r_i_ready`=0, at most `FDEPTH` words are accepted. `r_o_syn` drops in the cycle where `count + inflight` reaches `FDEPTH`.

## Structure
- Defaults for `IWIDTH` and `DEPTH` go in a shared include header, `instr_defs.vh` (include-guarded), used by both this block and the transmitter.
- Sub-module `instr_fifo`: synchronous FIFO, width `IWIDTH+IDXW`, depth `FDEPTH`.
  - Ports: push, pop, data in/out, count, full, empty.
  - Async active-low reset.
  - Simultaneous push/pop is legal when full.
- The top level holds the credit logic, `seq` counter, `last` decode and error flag.

## Test plan
- **Startup.** Bench transmitter model returns word i = `32'hA000_0000+i`. Release reset, then `r_i_en`=1 with `r_i_ready`=1 → first valid in cycle 2, `r_o_instr`=`A0000000`, `r_o_idx`=0; then one word per cycle with incrementing values.
- **Wrap.** Stream 40 words → the word at idx 35 shows `r_o_last`=1; the next word has idx 0, `r_o_instr`=`A0000000` (model wraps too); `r_o_err` stays 0.
- **Backpressure.** Hold `r_i_ready`=0 → exactly 4 words buffered, `r_o_syn` low once `count+inflight`=4, no overflow. Release → words 0..3 are output in order, then requests resume.
- **Enable toggle.** Drop `r_i_en` for 3 cycles mid-stream → the trailing ack is captured; no index gap or duplicate.
- **Forced overflow.** With the FIFO full and ready=0, inject an ack → the word is dropped, `r_o_err`=1 and stays set, and the next word's idx skips by one.
- **Mid-stream reset.** Assert `r_rst`=0 with 3 words buffered → `r_o_valid`, `r_o_syn`, `r_o_idx` and `r_o_err` go to 0 immediately (async); after release, the stream restarts at idx 0.

Source files
------------

// File: rtl/receive_pkg.sv
// Common constants and helpers for the instruction-fetch receiver.
package receive_pkg;
`include "instr_defs.vh"

    localparam int unsigned IWIDTH_DEF = `INSTR_IWIDTH;
    localparam int unsigned DEPTH_DEF  = `INSTR_DEPTH;
    localparam int unsigned FDEPTH_DEF = 32'd4;

    // Sequence index successor, wrapping back to zero after depth-1.
    function automatic int unsigned seq_next(input int unsigned seq, input int unsigned depth);
        int unsigned nxt;
        if (seq == (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = seq + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/instr_defs.vh
// Shared defaults for the instruction channel, used by the receiver and the transmitter.
`ifndef INSTR_DEFS_VH
`define INSTR_DEFS_VH
`define INSTR_IWIDTH 32
`define INSTR_DEPTH  36
`endif

// File: rtl/instr_fifo.sv
// Synchronous FIFO for tagged instruction words. Push and pop in the same cycle
// are legal even when full. When empty, dout keeps showing the last popped entry.
module instr_fifo #(
    parameter  int unsigned WIDTH = 32'd38,
    parameter  int unsigned DEPTH = 32'd4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 32'd1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

    // Head read: the entry at the read pointer, or the most recently popped one when empty.
    always_comb begin
        if (empty) begin
            dout = mem_q[rd_ptr_q - PW'(1)];
        end else begin
            dout = mem_q[rd_ptr_q];
        end
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears storage so the empty head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/receive.sv
// Instruction-fetch receiver: issues credit-limited syn requests, captures acked
// words with their sequence index and presents them on a valid/ready interface.
module receive
    import receive_pkg::*;
#(
    parameter int unsigned IWIDTH = IWIDTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned FDEPTH = FDEPTH_DEF,
    parameter int unsigned IDXW   = $clog2(DEPTH)
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_en,
    output logic              r_o_syn,
    input  logic [IWIDTH-1:0] r_i_instr,
    input  logic              r_i_ack,
    output logic [IWIDTH-1:0] r_o_instr,
    output logic [IDXW-1:0]   r_o_idx,
    output logic              r_o_last,
    output logic              r_o_valid,
    input  logic              r_i_ready,
    output logic              r_o_err
);

    localparam int unsigned EW = IWIDTH + IDXW;
    localparam int unsigned CW = $clog2(FDEPTH + 32'd1);

    logic [IDXW-1:0] seq_q, seq_d;
    logic            inflight_q, inflight_d;
    logic            err_q, err_d;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [EW-1:0]   fifo_dout_s;
    logic            push_s;
    logic            pop_s;
    logic            credit_ok_s;

    // Credit check: words held plus the one possibly in flight must leave room.
    // Pops this cycle are deliberately not credited, keeping syn free of ready/ack paths.
    always_comb begin
        credit_ok_s = ((32'(fifo_count_s) + 32'(inflight_q)) < FDEPTH);
        r_o_syn     = r_rst && r_i_en && credit_ok_s;
    end

    // Push/pop decisions, sequence advance and sticky overflow detection.
    always_comb begin
        pop_s      = !fifo_empty_s && r_i_ready;
        push_s     = r_i_ack && (!fifo_full_s || pop_s);
        inflight_d = r_o_syn;
        if (r_i_ack) begin
            seq_d = IDXW'(seq_next(32'(seq_q), DEPTH));
        end else begin
            seq_d = seq_q;
        end
        if (r_i_ack && fifo_full_s && !pop_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control registers; a dropped word still advances seq to stay in step with the source.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            seq_q      <= {IDXW{1'b0}};
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    instr_fifo #(
        .WIDTH (EW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (r_clk),
        .rst_n (r_rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({r_i_instr, seq_q}),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Head decode from the FIFO output entry.
    always_comb begin
        r_o_instr = fifo_dout_s[EW-1:IDXW];
        r_o_idx   = fifo_dout_s[IDXW-1:0];
        r_o_last  = (fifo_dout_s[IDXW-1:0] == IDXW'(DEPTH - 32'd1));
        r_o_valid = !fifo_empty_s;
        r_o_err   = err_q;
    end

endmodule
